// File: rtl/notch_noise_shaper.sv
`default_nettype none
// ============================================================================
// Module   : notch_noise_shaper
// Purpose  : Second-order error-feedback requantizer, NTF = -(1 + b1 z^-1 + z^-2)
// Revision : 1.0
// ============================================================================
module notch_noise_shaper #(
    parameter int WIDTH    = 16,
    parameter int OUT_BITS = 4,
    parameter int COEF_B1  = -31163,
    parameter int CNT_BITS = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [WIDTH-1:0]    x_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [OUT_BITS-1:0] q_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                overload_o,
    output logic [CNT_BITS-1:0] overload_cnt_o
);

    localparam int c_ew  = WIDTH + 2;
    localparam int c_vw  = WIDTH + 4;
    localparam int c_prw = WIDTH + c_ew;
    localparam int c_sh  = WIDTH - OUT_BITS;

    localparam logic signed [WIDTH-1:0] c_b1       = WIDTH'(COEF_B1);
    localparam logic signed [c_prw-1:0] c_p_rnd    = c_prw'(1 << 13);
    localparam logic signed [c_vw-1:0]  c_lsb_half = c_vw'(1 << (c_sh - 1));
    localparam logic signed [c_vw-1:0]  c_qmax     = c_vw'((1 << (OUT_BITS - 1)) - 1);
    localparam logic signed [c_vw-1:0]  c_qmin     = c_vw'(-(1 << (OUT_BITS - 1)));

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_SUM   = 3'd2,
        S_QUANT = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    logic signed [WIDTH-1:0]    r_x;
    logic signed [c_ew-1:0]     r_e1, r_e2;
    logic signed [c_vw-1:0]     r_p, r_v;
    logic [OUT_BITS-1:0]        r_q;
    logic                       r_ovf, r_valid;
    logic [CNT_BITS-1:0]        r_cnt;

    logic signed [c_prw-1:0]    w_b1x, w_e1x, w_prod;
    logic signed [c_vw-1:0]     w_p, w_v, w_qr, w_qc;
    logic signed [c_ew-1:0]     w_e;
    logic                       w_sat_hi, w_sat_lo, w_sat;

    // Q2.14 coefficient times error, rounded half up back to sample scale
    assign w_b1x  = c_prw'(c_b1);
    assign w_e1x  = c_prw'(r_e1);
    assign w_prod = (w_b1x * w_e1x) + c_p_rnd;
    assign w_p    = c_vw'(w_prod >>> 14);

    assign w_v    = c_vw'(r_x) - r_p - c_vw'(r_e2);

    assign w_qr     = (r_v + c_lsb_half) >>> c_sh;
    assign w_sat_hi = (w_qr > c_qmax);
    assign w_sat_lo = (w_qr < c_qmin);
    assign w_sat    = w_sat_hi | w_sat_lo;
    assign w_qc     = w_sat_hi ? c_qmax : (w_sat_lo ? c_qmin : w_qr);
    assign w_e      = c_ew'(r_v - (w_qc <<< c_sh));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid_i) w_state_nxt = S_MUL;
            S_MUL:   w_state_nxt = S_SUM;
            S_SUM:   w_state_nxt = S_QUANT;
            S_QUANT: w_state_nxt = S_OUT;
            S_OUT:   if (out_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_x     <= '0;
            r_e1    <= '0;
            r_e2    <= '0;
            r_p     <= '0;
            r_v     <= '0;
            r_q     <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) r_x <= x_i;
                end
                S_MUL: r_p <= w_p;
                S_SUM: r_v <= w_v;
                S_QUANT: begin
                    r_q     <= OUT_BITS'(w_qc);
                    r_ovf   <= w_sat;
                    r_valid <= 1'b1;
                    // Overload resets the loop so a clipped error cannot ring
                    if (w_sat) begin
                        r_e1 <= '0;
                        r_e2 <= '0;
                        if (r_cnt != {CNT_BITS{1'b1}}) r_cnt <= r_cnt + CNT_BITS'(1);
                    end else begin
                        r_e2 <= r_e1;
                        r_e1 <= w_e;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o     = (r_state == S_IDLE);
    assign q_o            = r_q;
    assign out_valid_o    = r_valid;
    assign overload_o     = r_ovf;
    assign overload_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_notch_noise_shaper.sv
`default_nettype none
// Scoreboard bench for notch_noise_shaper against an integer-arithmetic model.
module tb_notch_noise_shaper;

    localparam int WIDTH    = 16;
    localparam int OUT_BITS = 4;
    localparam int COEF_B1  = -31163;
    localparam int CNT_BITS = 2;
    localparam int LSB      = 1 << (WIDTH - OUT_BITS);
    localparam int QMAX     = (1 << (OUT_BITS - 1)) - 1;
    localparam int QMIN     = -(1 << (OUT_BITS - 1));
    localparam int CMAX     = (1 << CNT_BITS) - 1;

    logic                clk_i = 1'b0;
    logic                reset_i = 1'b1;
    logic [WIDTH-1:0]    x_i = '0;
    logic                in_valid_i = 1'b0;
    logic                in_ready_o;
    logic [OUT_BITS-1:0] q_o;
    logic                out_valid_o;
    logic                out_ready_i = 1'b1;
    logic                overload_o;
    logic [CNT_BITS-1:0] overload_cnt_o;

    notch_noise_shaper #(
        .WIDTH(WIDTH), .OUT_BITS(OUT_BITS), .COEF_B1(COEF_B1), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .x_i(x_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .q_o(q_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .overload_o(overload_o),
        .overload_cnt_o(overload_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int q;
        bit ov;
        int cnt;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   m_e1 = 0, m_e2 = 0, m_cnt = 0;
    bit   rand_ready = 1'b0;
    bit   ready_force = 1'b1;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #1;
        out_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        longint r;
        r = a / b;
        if ((a % b) != 0 && ((a < 0) != (b < 0))) r -= 1;
        return r;
    endfunction

    // Reference: direct evaluation of the error-feedback equations.
    task automatic model_push(input int x, input int acc);
        longint p, v, qr, e;
        exp_t   t;
        p  = fdiv(longint'(COEF_B1) * m_e1 + 8192, 16384);
        v  = x - p - m_e2;
        qr = fdiv(v + LSB / 2, LSB);
        t.ov = (qr > QMAX) || (qr < QMIN);
        t.q  = (qr > QMAX) ? QMAX : (qr < QMIN) ? QMIN : int'(qr);
        if (t.ov) begin
            m_e1 = 0;
            m_e2 = 0;
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            e    = v - longint'(t.q) * LSB;
            m_e2 = m_e1;
            m_e1 = int'(e);
        end
        t.cnt     = m_cnt;
        t.acc_cyc = acc;
        sb.push_back(t);
    endtask

    task automatic model_clear();
        sb.delete();
        m_e1 = 0; m_e2 = 0; m_cnt = 0;
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic send(input int x);
        int guard;
        in_valid_i = 1'b1;
        x_i        = x[WIDTH-1:0];
        guard      = 0;
        while (!in_ready_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        if (!in_ready_o) begin
            check("accept_timeout", 0, 1);
            in_valid_i = 1'b0;
            return;
        end
        model_push(x, cyc + 1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 400) begin
            @(negedge clk_i);
            guard++;
        end
        check("drain_timeout", sb.size(), 0);
        @(negedge clk_i);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_q"}, q_o, 0);
        check({tag, "_out_valid"}, out_valid_o, 0);
        check({tag, "_overload"}, overload_o, 0);
        check({tag, "_cnt"}, overload_cnt_o, 0);
        check({tag, "_in_ready"}, in_ready_o, 1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        model_clear();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        check_reset_state("reset");
    endtask

    // Monitor: pops on every output handshake, checks latency, hold and readiness.
    bit                  prev_valid = 1'b0;
    bit                  prev_hs = 1'b0;
    logic [OUT_BITS-1:0] prev_q = '0;
    logic                prev_ov = 1'b0;

    always @(negedge clk_i) begin
        exp_t t;
        if (reset_i) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) check("in_ready_after_hs", in_ready_o, 1);
            if (out_valid_o) begin
                if (!prev_valid) begin
                    if (sb.size() == 0) check("unexpected_output", 0, 1);
                    else check("latency", cyc - sb[0].acc_cyc, 3);
                end else begin
                    check("hold_q", q_o, prev_q);
                    check("hold_overload", overload_o, prev_ov);
                    check("in_ready_while_stalled", in_ready_o, 0);
                end
                if (out_ready_i && sb.size() > 0) begin
                    t = sb.pop_front();
                    check("q", $signed(q_o), t.q);
                    check("overload", overload_o, t.ov);
                    check("overload_cnt", overload_cnt_o, t.cnt);
                end
            end
            prev_valid = out_valid_o;
            prev_hs    = out_valid_o && out_ready_i;
            prev_q     = q_o;
            prev_ov    = overload_o;
        end
    end

    initial begin
        int x;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        check_reset_state("init");

        send(4096);
        drain();

        do_reset();
        send(2048); send(0); send(0);
        drain();

        do_reset();
        send(32767); send(-32768);
        drain();

        ready_force = 1'b0;
        @(negedge clk_i);
        send(1000);
        for (int i = 0; i < 10; i++) begin
            in_valid_i = 1'($urandom_range(0, 1));
            x_i        = WIDTH'($urandom);
            @(negedge clk_i);
        end
        in_valid_i  = 1'b0;
        ready_force = 1'b1;
        drain();

        for (int i = 0; i < 5; i++) send(32767);
        drain();
        check("cnt_saturated", overload_cnt_o, CMAX);

        do_reset();
        send(2048);
        @(negedge clk_i);
        reset_i = 1'b1;
        model_clear();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        check_reset_state("abort");
        repeat (8) @(negedge clk_i);

        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) x = $signed(WIDTH'($urandom));
            else x = $signed(16'($urandom_range(0, 16383))) - 8192;
            send(x);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(negedge clk_i);
        end
        drain();
        rand_ready = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
